cordic_pipe: RTL

CORDIC_PIPE -- requirements
Module: cordic_pipe

---
 rtl/cordic_if.sv | 28 ++
 rtl/cordic_pipe.sv | 134 +++++++++++++
 2 files changed

// File: rtl/cordic_if.sv
// Sample/result bus of the CORDIC pipeline: pipeline advance, strobed input
// sample and strobed result.
interface cordic_if #(
    parameter int BITWIDTH = 16,
    parameter int ZWIDTH   = 16
);
    logic                       enable;
    logic                       strobe_in;
    logic                       mode_in;
    logic signed [BITWIDTH-1:0] xi;
    logic signed [BITWIDTH-1:0] yi;
    logic signed [ZWIDTH-1:0]   zi;
    logic                       strobe_out;
    logic                       mode_out;
    logic signed [BITWIDTH-1:0] xo;
    logic signed [BITWIDTH-1:0] yo;
    logic signed [ZWIDTH-1:0]   zo;

    modport master (
        output enable, strobe_in, mode_in, xi, yi, zi,
        input  strobe_out, mode_out, xo, yo, zo
    );

    modport slave (
        input  enable, strobe_in, mode_in, xi, yi, zi,
        output strobe_out, mode_out, xo, yo, zo
    );
endinterface

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC, per-sample rotation or vectoring mode: one quadrant
// pre-rotation register followed by STAGES registered micro-rotations.
module cordic_pipe #(
    parameter int BITWIDTH = 16,
    parameter int ZWIDTH   = 16,
    parameter int STAGES   = 12
) (
    input  logic    clock,
    input  logic    reset,
    cordic_if.slave bus
);
    localparam int XW = BITWIDTH + 2;
    localparam logic [ZWIDTH-1:0] HALF_TURN = {1'b1, {(ZWIDTH-1){1'b0}}};

    generate
        if (STAGES < 4 || STAGES > ZWIDTH - 1) begin : g_bad_stages
            $error("cordic_pipe: STAGES must lie in 4..ZWIDTH-1");
        end
    endgenerate

    // atan(1/n) scaled by 2^62, from its alternating Taylor series
    function automatic logic [127:0] atan_inv_fx(input logic [127:0] n);
        logic [127:0] pw;
        logic [127:0] acc;
        pw  = (128'd1 << 62) / n;
        acc = '0;
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0)
                acc = acc + pw / 128'(2 * k + 1);
            else
                acc = acc - pw / 128'(2 * k + 1);
            pw = pw / (n * n);
        end
        return acc;
    endfunction

    // atan(2^-i) in angle counts; pi/4 comes from Machin's formula so the
    // whole table is exact integer arithmetic (c_0 is exactly 1/8 turn)
    function automatic logic signed [ZWIDTH-1:0] atan_const(input int i);
        logic [127:0] quarter_pi;
        logic [127:0] num;
        logic [127:0] res;
        quarter_pi = (atan_inv_fx(128'd5) << 2) - atan_inv_fx(128'd239);
        num        = atan_inv_fx(128'd1 << i) << (ZWIDTH - 3);
        if (i == 0)
            res = 128'd1 << (ZWIDTH - 3);
        else
            res = (num + (quarter_pi >> 1)) / quarter_pi;
        return ZWIDTH'(res);
    endfunction

    logic signed [XW-1:0]     x_reg [0:STAGES];
    logic signed [XW-1:0]     y_reg [0:STAGES];
    logic signed [ZWIDTH-1:0] z_reg [0:STAGES];
    logic [STAGES:0]          strobe_reg;
    logic [STAGES:0]          mode_reg;

    logic signed [XW-1:0]     x_next [0:STAGES-1];
    logic signed [XW-1:0]     y_next [0:STAGES-1];
    logic signed [ZWIDTH-1:0] z_next [0:STAGES-1];

    logic signed [XW-1:0]     x_ext;
    logic signed [XW-1:0]     y_ext;
    logic signed [XW-1:0]     x_pre_next;
    logic signed [XW-1:0]     y_pre_next;
    logic signed [ZWIDTH-1:0] z_pre_next;
    logic                     flip;

    assign x_ext = XW'(bus.xi);
    assign y_ext = XW'(bus.yi);

    // Fold the input into the right half-plane so the micro-rotations converge
    always_comb begin
        flip       = 1'b0;
        z_pre_next = '0;
        if (bus.mode_in) begin
            flip       = bus.xi[BITWIDTH-1];
            z_pre_next = flip ? HALF_TURN : '0;
        end else begin
            flip       = bus.zi[ZWIDTH-1] ^ bus.zi[ZWIDTH-2];
            z_pre_next = flip ? (bus.zi ^ HALF_TURN) : bus.zi;
        end
        x_pre_next = flip ? -x_ext : x_ext;
        y_pre_next = flip ? -y_ext : y_ext;
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam logic signed [ZWIDTH-1:0] ANGLE = atan_const(gi);
            logic                 d_pos;
            logic signed [XW-1:0] x_shift;
            logic signed [XW-1:0] y_shift;

            assign x_shift = x_reg[gi] >>> gi;
            assign y_shift = y_reg[gi] >>> gi;
            // vectoring drives y toward zero, rotation drives z toward zero
            assign d_pos   = mode_reg[gi] ? y_reg[gi][XW-1] : ~z_reg[gi][ZWIDTH-1];

            assign x_next[gi] = d_pos ? (x_reg[gi] - y_shift) : (x_reg[gi] + y_shift);
            assign y_next[gi] = d_pos ? (y_reg[gi] + x_shift) : (y_reg[gi] - x_shift);
            assign z_next[gi] = d_pos ? (z_reg[gi] - ANGLE)   : (z_reg[gi] + ANGLE);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s <= STAGES; s++) begin
                x_reg[s] <= '0;
                y_reg[s] <= '0;
                z_reg[s] <= '0;
            end
            strobe_reg <= '0;
            mode_reg   <= '0;
        end else if (bus.enable) begin
            x_reg[0]   <= x_pre_next;
            y_reg[0]   <= y_pre_next;
            z_reg[0]   <= z_pre_next;
            strobe_reg <= {strobe_reg[STAGES-1:0], bus.strobe_in};
            mode_reg   <= {mode_reg[STAGES-1:0], bus.mode_in};
            for (int s = 0; s < STAGES; s++) begin
                x_reg[s+1] <= x_next[s];
                y_reg[s+1] <= y_next[s];
                z_reg[s+1] <= z_next[s];
            end
        end
    end

    // Dropping the LSB halves the CORDIC gain to about 0.8234
    assign bus.xo         = x_reg[STAGES][BITWIDTH:1];
    assign bus.yo         = y_reg[STAGES][BITWIDTH:1];
    assign bus.zo         = z_reg[STAGES];
    assign bus.strobe_out = strobe_reg[STAGES];
    assign bus.mode_out   = mode_reg[STAGES];
endmodule
